// File: rtl/crossbar_pkg.sv
// Shared constants, state encodings and map type for the crossbar route solver.
// A map holds one 2-bit output index per input, input k+1 in bits [2k+1:2k].
package crossbar_pkg;

   localparam int NUM_PORTS = 4;
   localparam int DEST_W    = 2;
   localparam int NUM_SW    = 5;
   localparam int CTRL_W    = NUM_SW;
   localparam int CYC_W     = 6;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t SEARCH = 2'd1;
   localparam state_t DONE   = 2'd2;

   typedef logic [NUM_PORTS-1:0][DEST_W-1:0] map_t;

   // A map is a permutation when every output index appears exactly once.
   function automatic logic is_perm(input map_t m);
      logic [NUM_PORTS-1:0] seen;
      seen = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         seen[m[k]] = 1'b1;
      end
      return &seen;
   endfunction

endpackage

// File: rtl/crossbar_route_model.sv
// Combinational five-switch 2x2 network: for a control word, gives the source
// input index (0=in1..3=in4) that reaches each output.
module crossbar_route_model
   import crossbar_pkg::*;
(
   input  logic [CTRL_W-1:0]           control,
   output logic [NUM_PORTS*DEST_W-1:0] src
);

   logic [DEST_W-1:0] a, b, c, d, e, f;
   logic [DEST_W-1:0] o1, o2, o3, o4;

   // Each switch: 0 passes upper->upper, 1 swaps its two inputs.
   always_comb begin
      a  = control[0] ? 2'd1 : 2'd0;
      b  = control[0] ? 2'd0 : 2'd1;
      c  = control[1] ? 2'd3 : 2'd2;
      d  = control[1] ? 2'd2 : 2'd3;
      e  = control[2] ? c : b;
      f  = control[2] ? b : c;
      o1 = control[3] ? e : a;
      o2 = control[3] ? a : e;
      o3 = control[4] ? d : f;
      o4 = control[4] ? f : d;
   end

   assign src = {o4, o3, o2, o1};

endmodule

// File: rtl/crossbar_route_solver.sv
// Brute-force search for a crossbar control word realising a requested routing.
// Optional one-entry result cache: define CROSSBAR_ROUTE_SOLVER_CACHE_EN.
module crossbar_route_solver
   import crossbar_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [NUM_PORTS*DEST_W-1:0] req_dest,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic                        resp_found,
   output logic                        resp_bad_req,
   output logic [CTRL_W-1:0]           resp_control,
   output logic [CYC_W-1:0]            resp_cycles
);

   state_t            state_q, state_d;
   map_t              dest_q, dest_d;
   logic [CTRL_W-1:0] cand_q, cand_d;
   logic              found_q, found_d;
   logic              bad_q, bad_d;
   logic [CTRL_W-1:0] control_q, control_d;
   logic [CYC_W-1:0]  cycles_q, cycles_d;

   logic [NUM_PORTS*DEST_W-1:0] src_flat;
   map_t                        src;
   map_t                        req_map;
   logic                        match;
   logic                        cache_hit;
   logic [CTRL_W-1:0]           cache_ctrl;

   assign req_map = map_t'(req_dest);

   crossbar_route_model u_model (
      .control (cand_q),
      .src     (src_flat)
   );

   assign src = map_t'(src_flat);

   // Candidate matches when every input's requested output is fed by that input.
   always_comb begin
      match = 1'b1;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (src[dest_q[k]] != DEST_W'(k)) begin
            match = 1'b0;
         end
      end
   end

`ifdef CROSSBAR_ROUTE_SOLVER_CACHE_EN
   logic              cache_valid_q;
   map_t              cache_map_q;
   logic [CTRL_W-1:0] cache_ctrl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid_q <= 1'b0;
         cache_map_q   <= '0;
         cache_ctrl_q  <= '0;
      end else if (state_q == SEARCH && match) begin
         cache_valid_q <= 1'b1;
         cache_map_q   <= dest_q;
         cache_ctrl_q  <= cand_q;
      end
   end

   assign cache_hit  = cache_valid_q && (cache_map_q == req_map);
   assign cache_ctrl = cache_ctrl_q;
`else
   assign cache_hit  = 1'b0;
   assign cache_ctrl = '0;
`endif

   always_comb begin
      state_d   = state_q;
      dest_d    = dest_q;
      cand_d    = cand_q;
      found_d   = found_q;
      bad_d     = bad_q;
      control_d = control_q;
      cycles_d  = cycles_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               dest_d    = req_map;
               cand_d    = '0;
               found_d   = 1'b0;
               bad_d     = 1'b0;
               control_d = '0;
               cycles_d  = '0;
               if (!is_perm(req_map)) begin
                  bad_d   = 1'b1;
                  state_d = DONE;
               end else if (cache_hit) begin
                  found_d   = 1'b1;
                  control_d = cache_ctrl;
                  state_d   = DONE;
               end else begin
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            if (match) begin
               found_d   = 1'b1;
               control_d = cand_q;
               cycles_d  = {1'b0, cand_q} + 6'd1;
               state_d   = DONE;
            end else if (cand_q == 5'd31) begin
               // Exhausted without a match; counter stays put, no second pass.
               cycles_d = 6'd32;
               state_d  = DONE;
            end else begin
               cand_d = cand_q + 5'd1;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dest_q    <= '0;
         cand_q    <= '0;
         found_q   <= 1'b0;
         bad_q     <= 1'b0;
         control_q <= '0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         cand_q    <= cand_d;
         found_q   <= found_d;
         bad_q     <= bad_d;
         control_q <= control_d;
         cycles_q  <= cycles_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign resp_valid   = (state_q == DONE);
   assign resp_found   = found_q;
   assign resp_bad_req = bad_q;
   assign resp_control = control_q;
   assign resp_cycles  = cycles_q;

endmodule

// File: tb/tb_crossbar_route_solver.sv
// Directed-vector bench for crossbar_route_solver; expected results hand-derived
// from the switch network. Honours CROSSBAR_ROUTE_SOLVER_CACHE_EN for the repeat case.
module tb_crossbar_route_solver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_dest;
   logic       resp_valid;
   logic       resp_ready;
   logic       resp_found;
   logic       resp_bad_req;
   logic [4:0] resp_control;
   logic [5:0] resp_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [7:0] MAP_IDENT = 8'b11_10_01_00;
   localparam logic [7:0] MAP_SWAP  = 8'b11_10_00_01;
   localparam logic [7:0] MAP_REV   = 8'b00_01_10_11;
   localparam logic [7:0] MAP_SW34  = 8'b10_11_01_00;
   localparam logic [7:0] MAP_S2X   = 8'b11_01_10_00;
   localparam logic [7:0] MAP_DUP   = 8'b00_01_10_10;

   crossbar_route_solver dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_dest     (req_dest),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_found   (resp_found),
      .resp_bad_req (resp_bad_req),
      .resp_control (resp_control),
      .resp_cycles  (resp_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic reset_check(input string tag);
      check(tag, {resp_valid, resp_found, resp_bad_req, resp_control, resp_cycles}, 0);
   endtask

   task automatic accept(input logic [7:0] dest);
      int w = 0;
      while (!req_ready && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("accept.ready", req_ready, 1);
      req_valid = 1'b1;
      req_dest  = dest;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_dest  = ~dest;
   endtask

   // Latency counts the acceptance edge as 1.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [7:0] dest, input logic f, input logic b,
                      input logic [4:0] c, input logic [5:0] cy, input int elat, input int hold);
      int lat;
      accept(dest);
      check({tag, ".busy"}, req_ready, 0);
      wait_valid(lat);
      check({tag, ".lat"}, lat, elat);
      check({tag, ".found"}, resp_found, f);
      check({tag, ".bad"}, resp_bad_req, b);
      check({tag, ".control"}, resp_control, c);
      check({tag, ".cycles"}, resp_cycles, cy);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, ".hold"}, {resp_valid, req_ready, resp_found, resp_bad_req, resp_control,
               resp_cycles}, {1'b1, 1'b0, f, b, c, cy});
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check({tag, ".release"}, {resp_valid, req_ready}, 2'b01);
   endtask

   initial begin
      int lat;
      int seen;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_dest   = '0;
      resp_ready = 1'b0;
      #12;
      reset_check("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("por.ready", req_ready, 1);

      run("identity", MAP_IDENT, 1'b1, 1'b0, 5'd0, 6'd1, 2, 0);
      run("swap12", MAP_SWAP, 1'b1, 1'b0, 5'd1, 6'd2, 3, 0);
      run("bad_zero", 8'h00, 1'b0, 1'b1, 5'd0, 6'd0, 1, 0);
`ifdef CROSSBAR_ROUTE_SOLVER_CACHE_EN
      run("swap_cached", MAP_SWAP, 1'b1, 1'b0, 5'd1, 6'd0, 1, 0);
`else
      run("swap_again", MAP_SWAP, 1'b1, 1'b0, 5'd1, 6'd2, 3, 0);
`endif
      run("reverse", MAP_REV, 1'b0, 1'b0, 5'd0, 6'd32, 33, 0);
      run("swap34", MAP_SW34, 1'b1, 1'b0, 5'd2, 6'd3, 4, 0);
      run("s2_cross", MAP_S2X, 1'b1, 1'b0, 5'd4, 6'd5, 6, 0);
      run("bad_dup", MAP_DUP, 1'b0, 1'b1, 5'd0, 6'd0, 1, 0);
      run("hold", MAP_SW34, 1'b1, 1'b0, 5'd2, 6'd3, 4, 5);

      // Reset while searching: no response afterwards.
      accept(MAP_REV);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      reset_check("rst_search");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (resp_valid) seen++;
      end
      check("rst_search.noresp", seen, 0);
      check("rst_search.ready", req_ready, 1);

      // Reset while holding a found result.
      accept(MAP_SWAP);
      wait_valid(lat);
      check("rst_done.pre", {resp_valid, resp_found, resp_control}, {1'b1, 1'b1, 5'd1});
      #2;
      rst_n = 1'b0;
      #1;
      reset_check("rst_done");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_done.idle", {resp_valid, req_ready}, 2'b01);

      // Cache (if present) must have been cleared by reset.
      run("swap_after_rst", MAP_SWAP, 1'b1, 1'b0, 5'd1, 6'd2, 3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/crossbar_route_solver.md
CROSSBAR_ROUTE_SOLVER -- requirements
Module: crossbar_route_solver

Interface
REQ-001 SHALL have parameters: none; all widths fixed by crossbar_pkg constants (4 ports, 2-bit destination, 5 switches).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  solver can accept a request.
- req_dest  in  8  destination map; [2k+1:2k] = output index (0=out1..3=out4) for input k+1.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes the result.
- resp_found  out  1  a matching control word exists.
- resp_bad_req  out  1  req_dest was not a permutation.
- resp_control  out  5  crossbar control word; 0 when not found.
- resp_cycles  out  6  candidates evaluated, 0..32.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 Network model SHALL be five 2x2 switches, control[i] drives Si, 0=straight (upper in to upper out), 1=cross: S0(in1,in2)->(a,b); S1(in3,in4)->(c,d); S2(b,c)->(e,f); S3(a,e)->(out1,out2); S4(f,d)->(out3,out4).
REQ-005 FSM states SHALL be IDLE, SEARCH, DONE; req_ready=1 only in IDLE; resp_valid=1 only in DONE.
REQ-006 Acceptance SHALL occur on the rising edge with req_valid&&req_ready; req_dest is captured, later changes are ignored.
REQ-007 On acceptance, a non-permutation req_dest SHALL go to DONE with bad_req=1, found=0, control=0, cycles=0.
REQ-008 On acceptance, a valid permutation SHALL go to SEARCH with candidate=0.
REQ-009 Each SEARCH cycle SHALL evaluate one candidate, ascending from 0; first match wins: latch control=candidate, found=1, cycles=candidate+1, go to DONE.
REQ-010 After candidate 31 fails, the block SHALL go to DONE with found=0, control=0, cycles=32; the candidate counter does not wrap into a second pass.
REQ-011 resp_valid SHALL rise N+1 cycles after acceptance (N = candidates evaluated); bad request: 1 cycle.
REQ-012 resp_* SHALL remain stable while resp_valid&&!resp_ready; on resp_ready, return to IDLE the next cycle; no new request is accepted in the same cycle as the response handshake.

Reset
REQ-013 rst_n low SHALL, immediately and independent of clk, force IDLE, req_ready=1 once released, resp_valid=0, found=0, bad_req=0, control=0, cycles=0, candidate=0.
REQ-014 Reset during SEARCH or DONE SHALL discard the in-flight request with no response.

Configuration
REQ-015 Macro CROSSBAR_ROUTE_SOLVER_CACHE_EN defined: one-entry cache of the last found map; on acceptance of a matching map, go directly to DONE with cached control, found=1, cycles=0; updated only on found=1; cleared by reset.
REQ-016 Macro undefined: no cache storage; every valid request searches per REQ-008..010.

Structure
REQ-017 crossbar_pkg SHALL hold NUM_PORTS=4, DEST_W=2, NUM_SW=5, CTRL_W=5, the state enum and the map typedef.
REQ-018 Sub-module crossbar_route_model SHALL be the combinational REQ-004 network, mapping control to the source index per output; the solver compares its output against req_dest.

Verification
REQ-019 Identity req_dest=8'b11_10_01_00 -> resp_valid 2 cycles after acceptance, found=1, control=5'b00000, cycles=1.
REQ-020 Swap in1/in2, req_dest=8'b11_10_00_01 -> found=1, control=5'b00001, cycles=2.
REQ-021 Reversal req_dest=8'b00_01_10_11 -> found=0, control=0, cycles=32, resp_valid 33 cycles after acceptance.
REQ-022 req_dest=8'h00 -> bad_req=1, found=0, cycles=0, resp_valid 1 cycle after acceptance.
REQ-023 Hold resp_ready=0 for 5 cycles -> outputs stable, req_ready=0; assert rst_n=0 mid-SEARCH -> all outputs 0 immediately, IDLE after release.
REQ-024 With CACHE_EN, repeat the REQ-020 request -> found=1, control=5'b00001, cycles=0, resp_valid 1 cycle after acceptance.
